// File: rtl/note_decoder.sv
// Square-wave pitch decoder: times the half-period of tone_in, folds it into
// octave 0 and picks the nearest semitone, reporting octave*12 + note or 8'hFF.
`timescale 1ns/1ps
module note_decoder #(
    parameter int TIMEOUT = 1_600_000,
    parameter int MAX_OCT = 7
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        tone_in,
    output logic [7:0]  fullnote,
    output logic        note_valid,
    output logic        note_change,
    output logic [20:0] half_period
);
    localparam logic [23:0] LOW     = 24'd393592;
    localparam logic [23:0] HIGH    = 24'd787185;
    localparam logic [20:0] TO_LAST = 21'(TIMEOUT - 1);
    localparam logic [20:0] TO_SAT  = 21'(TIMEOUT);
    localparam logic [2:0]  OCT_MAX = 3'(MAX_OCT);
    localparam logic [7:0]  REST    = 8'hFF;

    typedef enum logic [1:0] {IDLE, NORM, SEARCH, COMMIT} state_t;

    function automatic logic [23:0] period_of(input logic [3:0] n);
        case (n)
            4'd0:    period_of = 24'd764456;
            4'd1:    period_of = 24'd721542;
            4'd2:    period_of = 24'd681050;
            4'd3:    period_of = 24'd642822;
            4'd4:    period_of = 24'd606752;
            4'd5:    period_of = 24'd572685;
            4'd6:    period_of = 24'd540552;
            4'd7:    period_of = 24'd510214;
            4'd8:    period_of = 24'd481575;
            4'd9:    period_of = 24'd454545;
            4'd10:   period_of = 24'd429037;
            4'd11:   period_of = 24'd404957;
            default: period_of = 24'd0;
        endcase
    endfunction

    function automatic logic [23:0] abs_diff(input logic [23:0] a, input logic [23:0] b);
        abs_diff = (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t      state, state_nx;
    logic        sync1, sync2, sync2_d;
    logic        edge_ev, measure, timeout;
    logic [20:0] cnt;
    logic        armed;
    logic [23:0] w, w_nx, best_d, best_d_nx, diff;
    logic [2:0]  oct, oct_nx;
    logic [3:0]  idx, idx_nx, best_n, best_n_nx;
    logic        rest, rest_nx;
    logic [7:0]  cand, result;
    logic        cand_ok;

    assign edge_ev = sync2 ^ sync2_d;
    // An edge landing exactly on the timeout cycle counts as a fresh first edge.
    assign measure = edge_ev && armed && (cnt != TO_LAST);
    assign timeout = armed && !edge_ev && (cnt == TO_LAST);
    assign diff    = abs_diff(w, period_of(idx));
    assign result  = rest ? REST : ({5'd0, oct} * 8'd12 + {4'd0, best_n});

    always_comb begin
        state_nx  = state;
        w_nx      = w;
        oct_nx    = oct;
        idx_nx    = idx;
        best_n_nx = best_n;
        best_d_nx = best_d;
        rest_nx   = rest;
        case (state)
            IDLE: begin
                if (measure) begin
                    w_nx     = {3'd0, cnt + 21'd1};
                    oct_nx   = 3'd0;
                    rest_nx  = 1'b0;
                    state_nx = NORM;
                end
            end
            NORM: begin
                if (w >= HIGH) begin
                    rest_nx  = 1'b1;
                    state_nx = COMMIT;
                end else if (w >= LOW) begin
                    idx_nx   = 4'd0;
                    state_nx = SEARCH;
                end else if (oct == OCT_MAX) begin
                    rest_nx  = 1'b1;
                    state_nx = COMMIT;
                end else begin
                    w_nx   = w << 1;
                    oct_nx = oct + 3'd1;
                end
            end
            SEARCH: begin
                // Strict less-than keeps the lower note on a tie.
                if (idx == 4'd0 || diff < best_d) begin
                    best_d_nx = diff;
                    best_n_nx = idx;
                end
                if (idx == 4'd11) state_nx = COMMIT;
                else              idx_nx   = idx + 4'd1;
            end
            COMMIT:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (edge_ev && state != IDLE) state_nx = IDLE;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1       <= 1'b0;
            sync2       <= 1'b0;
            sync2_d     <= 1'b0;
            state       <= IDLE;
            w           <= 24'd0;
            oct         <= 3'd0;
            idx         <= 4'd0;
            best_n      <= 4'd0;
            best_d      <= 24'd0;
            rest        <= 1'b0;
            cnt         <= 21'd0;
            armed       <= 1'b0;
            cand        <= REST;
            cand_ok     <= 1'b0;
            fullnote    <= REST;
            note_valid  <= 1'b0;
            note_change <= 1'b0;
            half_period <= 21'd0;
        end else begin
            sync1       <= tone_in;
            sync2       <= sync1;
            sync2_d     <= sync2;
            state       <= state_nx;
            w           <= w_nx;
            oct         <= oct_nx;
            idx         <= idx_nx;
            best_n      <= best_n_nx;
            best_d      <= best_d_nx;
            rest        <= rest_nx;
            note_change <= 1'b0;

            if (edge_ev) begin
                cnt   <= 21'd0;
                armed <= 1'b1;
            end else if (timeout) begin
                cnt   <= TO_SAT;
                armed <= 1'b0;
            end else if (armed) begin
                cnt <= cnt + 21'd1;
            end

            if (state == IDLE && measure) half_period <= cnt + 21'd1;

            // A result is only published once two consecutive measurements agree.
            if (edge_ev && state != IDLE) begin
                cand_ok <= 1'b0;
            end else if (timeout) begin
                cand_ok <= 1'b0;
                if (fullnote != REST) begin
                    fullnote    <= REST;
                    note_valid  <= 1'b0;
                    note_change <= 1'b1;
                end
            end else if (state == COMMIT) begin
                if (cand_ok && result == cand && result != fullnote) begin
                    fullnote    <= result;
                    note_valid  <= (result != REST);
                    note_change <= 1'b1;
                end
                cand    <= result;
                cand_ok <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_note_decoder.sv
// Scoreboard bench for note_decoder: stimulus queues expected note updates,
// a monitor checks every note_change pulse against the queue.
`timescale 1ns/1ps
module tb_note_decoder;
    localparam int TO = 8000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tone = 1'b0;
    logic [7:0]  fullnote;
    logic        note_valid, note_change;
    logic [20:0] half_period;

    typedef struct {
        logic [7:0] note;
        int         lo;
        int         hi;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   last_tog = 0;
    int   spent = 0;

    note_decoder #(.TIMEOUT(TO), .MAX_OCT(7)) dut (
        .clock(clk), .reset(rst_n), .tone_in(tone),
        .fullnote(fullnote), .note_valid(note_valid),
        .note_change(note_change), .half_period(half_period)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    endtask

    task automatic expect_note(input logic [7:0] n, input int lo, input int hi);
        sb.push_back('{note: n, lo: lo, hi: hi});
    endtask

    // Toggle tone exactly h cycles after the previous toggle.
    task automatic edge_at(input int h, input bit meas, input bit push, input logic [7:0] n);
        repeat (h - spent) @(negedge clk);
        tone = ~tone;
        last_tog = cyc;
        spent = 0;
        if (push) expect_note(n, last_tog + 2, last_tog + 27);
        if (meas) begin
            repeat (6) @(negedge clk);
            spent = 6;
            check("half_period", 32'(half_period), 32'(h));
        end
    endtask

    // Monitor
    always @(negedge clk) begin
        if (rst_n && note_change) begin
            if (sb.size() == 0) begin
                checks++;
                $display("FAIL spurious_pulse: fullnote %0h, expected no note_change (cycle %0d)", fullnote, cyc);
            end else begin
                automatic exp_t e = sb.pop_front();
                check("fullnote", 32'(fullnote), 32'(e.note));
                check("note_valid", 32'(note_valid), 32'(e.note != 8'hFF));
                check("pulse_timing", 32'(cyc >= e.lo && cyc <= e.hi), 32'd1);
            end
        end
    end

    initial begin
        #(150_000 * 10);
        $display("FAIL watchdog: simulation ran %0d cycles, expected completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_fullnote", 32'(fullnote), 32'hFF);
        check("rst_valid", 32'(note_valid), 32'd0);
        check("rst_change", 32'(note_change), 32'd0);
        check("rst_half", 32'(half_period), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // A at octave 7: arm, candidate, confirm, then steady
        edge_at(3553, 0, 0, 8'h00);
        edge_at(3553, 1, 0, 8'h00);
        check("first_two_edges_rest", 32'(fullnote), 32'hFF);
        edge_at(3553, 1, 1, 8'h5D);
        edge_at(3553, 1, 0, 8'h00);
        check("a_steady_note", 32'(fullnote), 32'h5D);
        check("a_steady_valid", 32'(note_valid), 32'd1);

        // Octave wrap: B at octave 6, then just below LOW folds to C of octave 7
        edge_at(6150, 1, 0, 8'h00);
        edge_at(6150, 1, 1, 8'd83);
        edge_at(6149, 1, 0, 8'h00);
        edge_at(6149, 1, 1, 8'd84);

        // Alternating pitches never confirm
        edge_at(3553, 1, 0, 8'h00);
        edge_at(3164, 1, 0, 8'h00);
        edge_at(3553, 1, 0, 8'h00);
        repeat (30) @(negedge clk);
        spent += 30;
        check("alternating_hold", 32'(fullnote), 32'd84);

        // Silence: forced rest TIMEOUT clocks after the last edge
        expect_note(8'hFF, last_tog + TO, last_tog + TO + 5);
        repeat (TO + 20) @(negedge clk);
        check("timeout_note", 32'(fullnote), 32'hFF);
        check("timeout_valid", 32'(note_valid), 32'd0);

        // New tone after timeout needs three edges again
        spent = 0;
        edge_at(100, 0, 0, 8'h00);
        edge_at(3553, 1, 0, 8'h00);
        repeat (30) @(negedge clk);
        spent += 30;
        check("retone_two_edges_rest", 32'(fullnote), 32'hFF);
        edge_at(3553, 1, 1, 8'h5D);

        // Too high in pitch even at MAX_OCT: confirmed rest
        edge_at(3000, 1, 0, 8'h00);
        edge_at(3000, 1, 1, 8'hFF);
        repeat (40) @(negedge clk);
        spent += 40;
        check("high_pitch_rest", 32'(fullnote), 32'hFF);
        check("high_pitch_valid", 32'(note_valid), 32'd0);

        // Reset in the middle of a valid tone
        edge_at(3553, 1, 0, 8'h00);
        edge_at(3553, 1, 1, 8'h5D);
        repeat (40) @(negedge clk);
        check("pre_reset_note", 32'(fullnote), 32'h5D);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_fullnote", 32'(fullnote), 32'hFF);
        check("async_rst_valid", 32'(note_valid), 32'd0);
        check("async_rst_change", 32'(note_change), 32'd0);
        check("async_rst_half", 32'(half_period), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        check("post_reset_note", 32'(fullnote), 32'hFF);
        check("queue_drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
